// File: rtl/latch_373_driver_pkg.sv
// Shared types, default timing and helpers for the 74x373 latch driver.
package latch_373_driver_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_SETUP = 2;
  localparam int DEF_PULSE = 3;
  localparam int DEF_HOLD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_373_driver_sync_fifo.sv
// Small synchronous FIFO buffering words for the latch driver; head shows the oldest entry.
module latch_373_driver_sync_fifo
  import latch_373_driver_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/latch_373_driver.sv
// Sequences buffered words onto a 74x373 latch bank with programmable setup/pulse/hold timing.
module latch_373_driver
  import latch_373_driver_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SETUP = DEF_SETUP,
  parameter int PULSE = DEF_PULSE,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             oe_en,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_le,
  output logic             lat_oc_n,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(max3(SETUP, PULSE, HOLD) + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             le_q, le_d;
  logic             done_q, done_d;
  logic             oc_q;
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] head;

  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign busy     = (state_q != ST_IDLE) || !empty;
  assign lat_d    = d_q;
  assign lat_le   = le_q;
  assign lat_oc_n = oc_q;
  assign done     = done_q;

  latch_373_driver_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wr_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      le_q    <= 1'b0;
      done_q  <= 1'b0;
      oc_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      le_q    <= le_d;
      done_q  <= done_d;
      oc_q    <= ~oe_en;
    end
  end

  // HOLD pops the next word straight into SETUP so back-to-back words have no idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    le_d    = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          d_d     = head;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          le_d    = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          le_d  = 1'b1;
          cnt_d = cnt_q - ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            d_d     = head;
            cnt_d   = SETUP_LD;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
